// File: rtl/opb_pkg.sv
// OPB decoder shared types: FSM encoding,
// error-response data default and error causes.
package opb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [31:0] ERR_DATA_DFLT =
    32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    UNMAPPED,
    ILLEGAL,
    TIMEOUT
  } err_cause_e;

endpackage

// File: rtl/opb_range_match.sv
// Single address-range comparator.
// Subtract form keeps top-of-map ranges safe.
module opb_range_match #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] size,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);

  logic [ADDR_W-1:0] ofs;

  assign ofs = addr - base;

  assign hit = (size != '0)
             && (addr >= base)
             && (ofs < size);

endmodule

// File: rtl/opb_addr_decode_n.sv
// Parametrised OPB address decoder with
// wait-state handshake, timeout and error log.
module opb_addr_decode_n
  import opb_pkg::*;
#(
  parameter int NUM_SL = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SL*ADDR_W-1:0]
    SL_BASE = '0,
  parameter logic [NUM_SL*ADDR_W-1:0]
    SL_SIZE = '0,
  parameter int TMO_CYC = 16,
  parameter logic [DATA_W-1:0]
    ERR_DATA = DATA_W'(ERR_DATA_DFLT)
) (
  input  logic                     OPB_CLK,
  input  logic                     OPB_RST_N,
  input  logic                     OPB_RE,
  input  logic                     OPB_WE,
  input  logic [ADDR_W-1:0]        OPB_ADDR,
  output logic [DATA_W-1:0]        OPB_DO,
  output logic                     OPB_ACK,
  output logic                     OPB_ERR,
  output logic [NUM_SL-1:0]        SL_RE,
  output logic [NUM_SL-1:0]        SL_WE,
  input  logic [NUM_SL-1:0]        SL_ACK,
  input  logic [NUM_SL*DATA_W-1:0] SL_DI,
  input  logic                     ERR_CLR,
  output logic [15:0]              ERR_CNT,
  output logic [ADDR_W-1:0]        ERR_ADDR
);

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TMO_CYC - 1);

  state_e            state;
  logic [NUM_SL-1:0] hit;
  logic [NUM_SL-1:0] sel;
  logic [NUM_SL-1:0] sel_q;
  logic              dir_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] sl_rdata;
  logic              ack_hit;
  logic              req;
  logic              illegal;
  logic              err_evt;
  logic [ADDR_W-1:0] err_at;

  for (genvar g = 0; g < NUM_SL; g++)
  begin : g_rm
    opb_range_match #(
      .ADDR_W(ADDR_W)
    ) u_rm (
      .base(SL_BASE[g*ADDR_W +: ADDR_W]),
      .size(SL_SIZE[g*ADDR_W +: ADDR_W]),
      .addr(OPB_ADDR),
      .hit (hit[g])
    );
  end

  assign req     = OPB_RE | OPB_WE;
  assign illegal = OPB_RE & OPB_WE;
  assign ack_hit = |(SL_ACK & sel_q);

  assign SL_RE = (state == ACCESS && dir_q)
               ? sel_q : '0;
  assign SL_WE = (state == ACCESS && !dir_q)
               ? sel_q : '0;

  // Lowest-index hit wins; result one-hot or zero
  always_comb begin
    sel = '0;
    for (int i = NUM_SL - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  // Read data of the latched slave
  always_comb begin
    sl_rdata = '0;
    for (int i = 0; i < NUM_SL; i++) begin
      if (sel_q[i])
        sl_rdata = SL_DI[i*DATA_W +: DATA_W];
    end
  end

  // Detect an error response and its address
  always_comb begin
    err_evt = 1'b0;
    err_at  = OPB_ADDR;
    case (state)
      IDLE: begin
        if (req && (illegal || sel == '0))
          err_evt = 1'b1;
      end
      ACCESS: begin
        if (!ack_hit && timer == TMO_LAST) begin
          err_evt = 1'b1;
          err_at  = addr_q;
        end
      end
      default: ;
    endcase
  end

  // Transfer FSM with registered responses
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state   <= IDLE;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      timer   <= '0;
      OPB_DO  <= '0;
      OPB_ACK <= 1'b0;
      OPB_ERR <= 1'b0;
    end else begin
      OPB_ACK <= 1'b0;
      OPB_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (illegal || sel == '0) begin
              OPB_ACK <= 1'b1;
              OPB_ERR <= 1'b1;
              if (OPB_RE)
                OPB_DO <= ERR_DATA;
              state <= RESP;
            end else begin
              sel_q  <= sel;
              dir_q  <= OPB_RE;
              addr_q <= OPB_ADDR;
              timer  <= '0;
              state  <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            if (dir_q)
              OPB_DO <= sl_rdata;
            OPB_ACK <= 1'b1;
            state   <= RESP;
          end else if (timer == TMO_LAST) begin
            if (dir_q)
              OPB_DO <= ERR_DATA;
            OPB_ACK <= 1'b1;
            OPB_ERR <= 1'b1;
            state   <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Error counter and last-error address
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      ERR_CNT  <= '0;
      ERR_ADDR <= '0;
    end else if (err_evt) begin
      if (ERR_CLR)
        ERR_CNT <= 16'd1;
      else if (ERR_CNT != 16'hFFFF)
        ERR_CNT <= ERR_CNT + 16'd1;
      ERR_ADDR <= err_at;
    end else if (ERR_CLR) begin
      ERR_CNT  <= '0;
      ERR_ADDR <= '0;
    end
  end

endmodule
